// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory map, access size encodings and LSU state type
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] IMEM_END  = 32'h0000_4000;
    localparam logic [31:0] DMEM_BASE = 32'h0000_4000;
    localparam logic [31:0] DMEM_END  = 32'h0000_8000;
    localparam logic [31:0] MEM_END   = DMEM_END;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2
    } lsu_state_t;

    // 33-bit sum so an access wrapping past 2^32 lands above MEM_END and faults.
    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] last;
        logic [32:0] span;
        case (size)
            SZ_BYTE: span = 33'd0;
            SZ_HALF: span = 33'd1;
            default: span = 33'd3;
        endcase
        last = {1'b0, addr} + span;
        return (size == SZ_RSVD) || (last >= {1'b0, MEM_END});
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and BRAM port bundle for the LSU
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane mask/data positioning for stores, merge and extend for loads
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [7:0]  mask64,
    output logic [63:0] data64,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [31:0] ld_data
);

    logic [7:0]  base_mask;
    logic [63:0] pair;
    logic [31:0] merged;

    always_comb begin
        case (st_size)
            SZ_BYTE: base_mask = 8'h01;
            SZ_HALF: base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
    end

    assign mask64 = base_mask << st_off;
    assign data64 = {32'd0, st_wdata} << {st_off, 3'b000};

    assign pair   = {word1, word0} >> {ld_off, 3'b000};
    assign merged = pair[31:0];

    always_comb begin
        ld_data = merged;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'd0, merged[7:0]}
                                           : {{24{merged[7]}}, merged[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {16'd0, merged[15:0]}
                                           : {{16{merged[15]}}, merged[15:0]};
            default: ld_data = merged;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for one BRAM port with split and fault handling
module load_store_unit
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    lsu_state_t  state, state_n;
    logic        accept;
    logic        done;
    logic        fault_now;
    logic        split_now;

    logic        we_q;
    logic        uns_q;
    logic        fault_q;
    logic        split_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word0_q;

    logic        rsp_valid_q;
    logic        rsp_fault_q;
    logic [31:0] rsp_rdata_q;

    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic [31:0] al_wdata;
    logic [7:0]  mask64;
    logic [63:0] data64;
    logic [31:0] ld_word0;
    logic [31:0] ld_data;

    logic [3:0]  mem_we_c;
    logic [31:0] mem_addr_c;
    logic [31:0] mem_wdata_c;

    assign bus.req_ready = (state == ST_IDLE) && rst_n;
    assign accept        = bus.req_valid && bus.req_ready;

    // The first beat is driven straight from the live request; later beats use the latched copy.
    assign al_size  = (state == ST_IDLE) ? bus.req_size         : size_q;
    assign al_off   = (state == ST_IDLE) ? bus.req_addr[1:0]    : addr_q[1:0];
    assign al_wdata = (state == ST_IDLE) ? bus.req_wdata        : wdata_q;
    assign ld_word0 = (state == ST_BEAT2) ? word0_q : bus.mem_rdata;

    assign fault_now = access_fault(bus.req_addr, bus.req_size);
    assign split_now = |mask64[7:4];

    lsu_lane_align u_align (
        .st_size     (al_size),
        .st_off      (al_off),
        .st_wdata    (al_wdata),
        .mask64      (mask64),
        .data64      (data64),
        .ld_size     (size_q),
        .ld_off      (addr_q[1:0]),
        .ld_unsigned (uns_q),
        .word0       (ld_word0),
        .word1       (bus.mem_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_n     = state;
        done        = 1'b0;
        mem_we_c    = 4'd0;
        mem_addr_c  = 32'd0;
        mem_wdata_c = 32'd0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_c = {bus.req_addr[31:2], 2'b00};
                    if (bus.req_we && !fault_now) begin
                        mem_we_c    = mask64[3:0];
                        mem_wdata_c = data64[31:0];
                    end
                    state_n = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                if (split_q && !fault_q) begin
                    mem_addr_c = {addr_q[31:2], 2'b00} + 32'd4;
                    if (we_q) begin
                        mem_we_c    = mask64[7:4];
                        mem_wdata_c = data64[63:32];
                    end
                    state_n = ST_BEAT2;
                end else begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_BEAT2: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            fault_q     <= 1'b0;
            split_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            word0_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state       <= state_n;
            rsp_valid_q <= done;
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                fault_q <= fault_now;
                split_q <= split_now;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ST_BEAT1) begin
                word0_q <= bus.mem_rdata;
            end
            if (done) begin
                rsp_fault_q <= fault_q;
                rsp_rdata_q <= (we_q || fault_q) ? 32'd0 : ld_data;
            end
        end
    end

    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int accept_cnt = 0;
    int rsp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] bram [0:8191];
    logic [7:0]  ref_mem [0:32767];

    always @(posedge clk) begin
        bus.mem_rdata <= bram[bus.mem_addr[14:2]];
        for (int i = 0; i < 4; i++)
            if (bus.mem_we[i]) bram[bus.mem_addr[14:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [3:0]  log_we    [int];
    logic [31:0] log_addr  [int];
    logic [31:0] log_wdata [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        log_we[cyc]    = bus.mem_we;
        log_addr[cyc]  = bus.mem_addr;
        log_wdata[cyc] = bus.mem_wdata;
        if (rst_n && bus.req_valid && bus.req_ready) accept_cnt++;
        if (bus.mem_we != 4'd0) check("mem_addr_aligned", 32'(bus.mem_addr[1:0]), 32'd0);
        if (bus.rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_expected", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic logic ref_fault(input logic [1:0] size, input logic [31:0] addr);
        longint last;
        if (size == 2'd3) return 1'b1;
        last = longint'({32'd0, addr}) + (longint'(1) << size) - 1;
        return last >= longint'({32'd0, MEM_END});
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[15'(addr + 32'(i))]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit push, output int acc);
        int waitc;
        int n;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        #1;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (push) begin
            n = 1 << size;
            e.fault = ref_fault(size, addr);
            if (e.fault) begin
                e.cyc   = acc + 2;
                e.rdata = 32'd0;
            end else begin
                e.cyc   = (int'(addr[1:0]) + n > 4) ? acc + 3 : acc + 2;
                e.rdata = we ? 32'd0 : ref_load(size, uns, addr);
                if (we)
                    for (int i = 0; i < n; i++) ref_mem[15'(addr + 32'(i))] = wdata[8*i +: 8];
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc, acc_b, c0, r0;
        logic [31:0] w;
        logic [31:0] a;
        logic [1:0]  sz;
        int r;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_BYTE;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        for (int i = 0; i < 8192; i++) begin
            w = $urandom;
            bram[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        repeat (3) @(negedge clk);
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, SZ_WORD, 1'b0, 32'h5000, 32'hDEADBEEF, 1'b1, acc);
        idle(3);
        check("sw_b1_we", 32'(log_we[acc]), 32'hF);
        check("sw_b1_addr", log_addr[acc], 32'h5000);
        check("sw_b1_wdata", log_wdata[acc], 32'hDEADBEEF);
        check("sw_after_we", 32'(log_we[acc+1]), 32'd0);
        check("sw_after_addr", log_addr[acc+1], 32'd0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'd0, 1'b1, acc);
        idle(3);

        issue(1'b1, SZ_WORD, 1'b0, 32'h5000, 32'h80FF1234, 1'b1, acc);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h5003, 32'd0, 1'b1, acc);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h5003, 32'd0, 1'b1, acc);
        issue(1'b0, SZ_HALF, 1'b0, 32'h5002, 32'd0, 1'b1, acc);
        idle(3);

        issue(1'b1, SZ_WORD, 1'b0, 32'h5002, 32'h11223344, 1'b1, acc);
        idle(4);
        check("split_b1_we", 32'(log_we[acc]), 32'hC);
        check("split_b1_addr", log_addr[acc], 32'h5000);
        check("split_b1_wdata", log_wdata[acc], 32'h33440000);
        check("split_b2_we", 32'(log_we[acc+1]), 32'h3);
        check("split_b2_addr", log_addr[acc+1], 32'h5004);
        check("split_b2_wdata", log_wdata[acc+1], 32'h00001122);
        issue(1'b0, SZ_WORD, 1'b0, 32'h5002, 32'd0, 1'b1, acc);
        idle(4);

        issue(1'b1, SZ_WORD, 1'b0, 32'h7FFE, 32'hCAFEF00D, 1'b1, acc);
        idle(4);
        for (int k = 0; k < 3; k++) check("fault_end_we", 32'(log_we[acc+k]), 32'd0);
        issue(1'b1, SZ_RSVD, 1'b0, 32'h5000, 32'h55AA55AA, 1'b1, acc);
        idle(4);
        for (int k = 0; k < 3; k++) check("fault_rsvd_we", 32'(log_we[acc+k]), 32'd0);
        drain();

        c0 = accept_cnt;
        issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'd0, 1'b1, acc);
        issue(1'b0, SZ_WORD, 1'b0, 32'h5004, 32'd0, 1'b1, acc_b);
        idle(1);
        while (cyc < acc + 6) @(posedge clk);
        @(negedge clk);
        #3;
        check("tput_accepts", 32'(accept_cnt - c0), 32'd2);
        check("tput_spacing", 32'(acc_b - acc), 32'd2);
        drain();

        issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'd0, 1'b0, acc);
        #1;
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        r0 = rsp_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check("midrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'd0, 1'b1, acc);
        idle(1);
        drain();

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = 32'h5000 + $urandom_range(0, 63);
            else if (r < 90) a = 32'h7FF0 + $urandom_range(0, 15);
            else             a = $urandom;
            r = $urandom_range(0, 9);
            sz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : SZ_RSVD;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, acc);
            if ($urandom_range(0, 9) < 4) idle($urandom_range(1, 3));
        end
        idle(1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory initiator for one port of the dual-port BRAM, sitting between the core's memory stage and the BRAM data port. It accepts byte, half and word load/store requests and generates byte-lane write enables and shifted write data. It extracts and sign- or zero-extends read data from the BRAM's one-cycle, read-first output. Accesses that straddle a 32-bit word are split into two BRAM beats, and accesses beyond the memory range are faulted without touching memory.

## Interface
- MEM_END, 32'h00008000, first byte address past the end of memory; any byte at or above this faults
- clk  in  1  clock; BRAM shares it
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE with rst_n high; accept = req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved (faults)
- req_unsigned  in  1  zero-extend loads (ignored for stores and word size)
- req_addr  in  32  byte address, any alignment
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualified by rsp_valid
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  32  BRAM byte address, always word-aligned (addr[1:0] = 0)
- mem_wdata  out  32  BRAM write data, lane-positioned
- mem_rdata  in  32  BRAM read data, valid the cycle after mem_addr is presented

## Operation
- States: IDLE, BEAT1, BEAT2.
- Per-request values:
  - off = req_addr[1:0]
  - 8-bit mask64 = {1, 3, F}[size] << off
  - 64-bit data64 = req_wdata << 8*off
- Split iff mask64[7:4] != 0.
- Fault iff size == 3 or the last byte address (addr + bytes - 1) >= MEM_END. Wrap past 2^32 also faults.
- IDLE, on accept, combinationally drive:
  - mem_addr = addr & ~3
  - for a non-faulting store: mem_we = mask64[3:0], mem_wdata = data64[31:0]
  - otherwise mem_we = 0
  - Go to BEAT1 and latch the request.
- BEAT1:
  - Capture mem_rdata as word0.
  - Non-split or fault: register the response and return to IDLE.
  - Split, non-fault: drive mem_addr = (addr & ~3) + 4 and, for stores, mem_we = mask64[7:4], mem_wdata = data64[63:32]. Go to BEAT2.
- BEAT2: capture mem_rdata as word1, register the response, return to IDLE.
- Load result:
  - merged = ({word1, word0} >> 8*off)[31:0]
  - Mask to size; sign-extend from bit 7 or bit 15 unless req_unsigned.
- Faulting requests never assert mem_we in any beat. A split store whose second word is out of range writes nothing.
- Outside accepted beats: mem_we = 0, mem_addr = 0, mem_wdata = 0.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_fault 0, mem_we 0, mem_addr 0, mem_wdata 0, req_ready 0 while rst_n is low.
- Accept in cycle N:
  - non-split: rsp_valid in cycle N+2
  - split: rsp_valid in cycle N+3
  - fault: rsp_valid in cycle N+2
- req_ready drops in the cycle after accept and returns high in the rsp_valid cycle. A new request can be accepted in the same cycle as rsp_valid, giving a maximum throughput of one non-split access per 2 cycles.
- req_* inputs are sampled only at accept; changes while busy are ignored.
- Reset asserted mid-operation:
  - Immediately return to IDLE and clear mem_we; no response is produced.
  - If reset hits in BEAT2 of a split store, the first beat may already be written; this is accepted, not rolled back.

## Structure
- Package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), MEM_END and the IMEM/DMEM bounds, the state enum.
- Sub-module lsu_lane_align (combinational): mask64/data64 generation and load merge/extend. The FSM and registers stay in load_store_unit.

## Test plan
- Word store 0xDEADBEEF @0x5000 -> mem_we 4'hF, mem_addr 0x5000. Word load @0x5000 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly at N+2.
- With 0x80FF1234 @0x5000:
  - signed byte load @0x5003 -> 0xFFFFFF80; unsigned -> 0x00000080
  - signed half load @0x5002 -> 0xFFFF80FF
- Word store 0x11223344 @0x5002 -> beat 1 {addr 0x5000, we 4'hC, wdata 0x33440000}, beat 2 {addr 0x5004, we 4'h3, wdata 0x00001122}. Word load @0x5002 -> 0x11223344 at N+3.
- Word store @0x7FFE -> rsp_fault 1, rsp_rdata 0, mem_we 0 in every cycle, latency 2. Size 3 @0x5000 -> fault.
- req_valid held high for 6 cycles with two distinct requests -> exactly two accepts, spaced 2 cycles apart (non-split), responses in order.
- rst_n pulsed low in BEAT1 of a load -> no rsp_valid, mem_we 0 immediately. The first request after release completes normally.
